ddr_iod_rd_eye_trainer: RTL and testbench
=========================================

# ddr_iod_rd_eye_trainer

Read-gate eye trainer for one DDR4 DQ lane IOD (one IOD per bit).
- Sweeps the IOD receive delay line one tap at a time and checks the eye-monitor EARLY/LATE flags at each tap.
- Finds the first contiguous passing window, then reloads the delay line and steps it to the window centre.
- Sits between the lane's training sequencer and the IOD dynamic-delay and eye-monitor controls, in the FAB_CLK domain.

## Interface
Parameters:
- TAP_MAX, 127: highest tap index swept; index is relative to the delay-line load value.
- SETTLE_CYC, 8: wait cycles after a clear, move or load before sampling.
- SAMPLE_CYC, 16: cycles over which EARLY/LATE are accumulated per tap.
- MIN_WIDTH, 4: minimum passing taps; used only with DDR_RD_TRAIN_MIN_WIDTH_EN.

Ports:
- FAB_CLK  in  1  single clock; all logic is rising-edge.
- ARST_N  in  1  asynchronous active-low reset.
- TRAIN_START  in  1  one-cycle start request; ignored while TRAIN_BUSY=1.
- TRAIN_BUSY  out  1  high from the cycle after accepted start until DONE or ERR.
- TRAIN_DONE  out  1  level; training succeeded; cleared by the next accepted start.
- TRAIN_ERR  out  1  level; training failed; cleared by the next accepted start.
- TAP_CENTER  out  8  centre tap; valid while TRAIN_DONE=1.
- DELAY_LINE_LOAD  out  1  one-cycle pulse; returns the delay line to its load value.
- DELAY_LINE_MOVE  out  1  one-cycle pulse; moves the delay line one tap.
- DELAY_LINE_DIRECTION  out  1  held at 1 (increment) throughout.
- DELAY_LINE_OUT_OF_RANGE  in  1  IOD range flag.
- EYE_MONITOR_CLEAR_FLAGS  out  1  one-cycle pulse; clears the EARLY/LATE flags.
- EYE_MONITOR_EARLY, EYE_MONITOR_LATE  in  1 each  IOD eye flags.

## Operation
Reset values:
- TRAIN_BUSY, TRAIN_DONE, TRAIN_ERR, DELAY_LINE_LOAD, DELAY_LINE_MOVE, EYE_MONITOR_CLEAR_FLAGS = 0.
- DELAY_LINE_DIRECTION = 1.
- TAP_CENTER = 0; state = IDLE.

State sequence:
- IDLE: on TRAIN_START, clear DONE/ERR, set tap=0, found=0 and go to LOAD.
- LOAD: DELAY_LINE_LOAD=1 for one cycle, then go to CLEAR.
- CLEAR: EYE_MONITOR_CLEAR_FLAGS=1 for one cycle, then go to SETTLE.
- SETTLE: wait SETTLE_CYC cycles, then go to SAMPLE.
- SAMPLE: OR-accumulate EARLY|LATE into `bad` for SAMPLE_CYC cycles, then go to EVAL.
- EVAL, the tap passes when bad=0:
  - Pass and found=0: first=tap, last=tap, found=1.
  - Pass and found=1: last=tap.
  - Fail and found=1: window closed; go to CENTER.
  - Otherwise, if tap==TAP_MAX: go to CENTER if found=1, else ERR.
  - Otherwise go to STEP.
- STEP: DELAY_LINE_MOVE=1 for one cycle, tap+=1, then go to CLEAR.
- CENTER:
  - TAP_CENTER = (first+last)>>1, computed with a 9-bit sum and truncated (floor).
  - Then LOAD pulse, SETTLE_CYC wait, then TAP_CENTER MOVE pulses spaced two cycles apart (pulse, gap).
  - Then go to DONE.
- DONE: TRAIN_DONE=1, BUSY=0, go to IDLE while holding DONE.
- ERR: TRAIN_ERR=1, BUSY=0, go to IDLE while holding ERR.

Rules:
- DELAY_LINE_OUT_OF_RANGE=1 is sampled every cycle in SETTLE, SAMPLE and the centre-move phase.
  - Any occurrence sends the block to ERR on the next cycle; no further pulses are issued.
- LOAD, MOVE and CLEAR pulses are mutually exclusive; there are never two in one cycle.
- Reset mid-operation returns all outputs to reset values at once. The delay line is not restored; the next training run reloads it.
- TRAIN_START while busy has no effect and is not queued.

## Timing
- Start to first LOAD pulse: 1 cycle, with BUSY asserted the same cycle as LOAD.
- Per tap: 1 (CLEAR) + SETTLE_CYC + SAMPLE_CYC + 1 (EVAL) + 1 (STEP) = SETTLE_CYC+SAMPLE_CYC+3 cycles. With defaults this is 27.
- The EARLY/LATE value in the cycle after CLEAR belongs to SETTLE and is ignored.
- Centre phase: 1 + 1 + SETTLE_CYC + 2*TAP_CENTER cycles, then DONE.
- DONE/ERR are asserted the cycle BUSY falls.

## Configuration
- DDR_RD_TRAIN_MIN_WIDTH_EN defined:
  - In CENTER, if (last-first+1) < MIN_WIDTH, go to ERR instead of centring.
  - No LOAD or MOVE is issued in that case.
- DDR_RD_TRAIN_MIN_WIDTH_EN undefined:
  - Any window of one or more taps is accepted.
  - MIN_WIDTH is unused.

## Test plan
- Eye model passes taps 10..30, fails elsewhere -> sweep stops at tap 31; TAP_CENTER=20; 20 MOVE pulses after the centre LOAD; TRAIN_DONE=1.
- No passing tap (EARLY stuck 1) -> 128 taps evaluated, 127 MOVE pulses; TRAIN_ERR=1, TAP_CENTER=0.
- DELAY_LINE_OUT_OF_RANGE raised during SAMPLE at tap 5 -> ERR next cycle; no further MOVE pulses.
- Pass window 10..12:
  - With DDR_RD_TRAIN_MIN_WIDTH_EN and MIN_WIDTH=4 -> TRAIN_ERR=1.
  - Without it -> TAP_CENTER=11, TRAIN_DONE=1.
- Pass window 120..127 (never closes) -> TAP_CENTER=123, TRAIN_DONE=1.
- ARST_N low at tap 40, then released, then TRAIN_START; also pulse TRAIN_START while busy -> all outputs 0 during reset; restart begins with a LOAD pulse; the busy-time start is ignored.

Source files
------------

// File: rtl/ddr_iod_rd_eye_trainer.sv
// Read-gate eye trainer for one DDR4 DQ bit IOD: sweeps the receive delay line, finds the first passing window, centres on it.
// Optional build macro DDR_RD_TRAIN_MIN_WIDTH_EN rejects windows narrower than MIN_WIDTH taps.
module ddr_iod_rd_eye_trainer #(
  parameter int TAP_MAX    = 127,
  parameter int SETTLE_CYC = 8,
  parameter int SAMPLE_CYC = 16,
  parameter int MIN_WIDTH  = 4
) (
  input  logic       FAB_CLK,
  input  logic       ARST_N,
  input  logic       TRAIN_START,
  output logic       TRAIN_BUSY,
  output logic       TRAIN_DONE,
  output logic       TRAIN_ERR,
  output logic [7:0] TAP_CENTER,
  output logic       DELAY_LINE_LOAD,
  output logic       DELAY_LINE_MOVE,
  output logic       DELAY_LINE_DIRECTION,
  input  logic       DELAY_LINE_OUT_OF_RANGE,
  output logic       EYE_MONITOR_CLEAR_FLAGS,
  input  logic       EYE_MONITOR_EARLY,
  input  logic       EYE_MONITOR_LATE
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_LOAD    = 4'd1;
  localparam logic [3:0] S_CLEAR   = 4'd2;
  localparam logic [3:0] S_SETTLE  = 4'd3;
  localparam logic [3:0] S_SAMPLE  = 4'd4;
  localparam logic [3:0] S_EVAL    = 4'd5;
  localparam logic [3:0] S_STEP    = 4'd6;
  localparam logic [3:0] S_CENTER  = 4'd7;
  localparam logic [3:0] S_CLOAD   = 4'd8;
  localparam logic [3:0] S_CSETTLE = 4'd9;
  localparam logic [3:0] S_CMOVE   = 4'd10;
  localparam logic [3:0] S_CGAP    = 4'd11;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] SAMPLE_LAST = 16'(SAMPLE_CYC - 1);
  localparam logic [7:0]  TAP_LAST    = 8'(TAP_MAX);

  // Without the width check every found window (width >= 1) is accepted.
`ifdef DDR_RD_TRAIN_MIN_WIDTH_EN
  localparam int MIN_REQ = MIN_WIDTH;
`else
  localparam int MIN_REQ = (MIN_WIDTH > 0) ? 1 : 1;
`endif

  logic [3:0]  state;
  logic [15:0] cnt;
  logic [7:0]  tap;
  logic [7:0]  first;
  logic [7:0]  last;
  logic [7:0]  mv_left;
  logic        found;
  logic        bad;
  logic        done_q;
  logic        err_q;
  logic [7:0]  center_q;
  logic [8:0]  sum;
  logic [8:0]  width;
  logic        win_short;

  assign sum       = {1'b0, first} + {1'b0, last};
  assign width     = {1'b0, last} - {1'b0, first} + 9'd1;
  assign win_short = (width < 9'(MIN_REQ));

  assign TRAIN_BUSY              = (state != S_IDLE);
  assign TRAIN_DONE              = done_q;
  assign TRAIN_ERR               = err_q;
  assign TAP_CENTER              = center_q;
  assign DELAY_LINE_LOAD         = (state == S_LOAD) || (state == S_CLOAD);
  assign DELAY_LINE_MOVE         = (state == S_STEP) || (state == S_CMOVE);
  assign DELAY_LINE_DIRECTION    = 1'b1;
  assign EYE_MONITOR_CLEAR_FLAGS = (state == S_CLEAR);

  // Completion goes straight back to IDLE with the result flag held, so BUSY falls as DONE/ERR rise.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state    <= S_IDLE;
      cnt      <= '0;
      tap      <= '0;
      first    <= '0;
      last     <= '0;
      mv_left  <= '0;
      found    <= 1'b0;
      bad      <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      center_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (TRAIN_START) begin
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            tap      <= '0;
            found    <= 1'b0;
            center_q <= '0;
            state    <= S_LOAD;
          end
        end
        S_LOAD: state <= S_CLEAR;
        S_CLEAR: begin
          cnt   <= '0;
          bad   <= 1'b0;
          state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (DELAY_LINE_OUT_OF_RANGE) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end else if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= S_SAMPLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_SAMPLE: begin
          if (DELAY_LINE_OUT_OF_RANGE) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end else begin
            bad <= bad | EYE_MONITOR_EARLY | EYE_MONITOR_LATE;
            if (cnt == SAMPLE_LAST) state <= S_EVAL;
            else cnt <= cnt + 16'd1;
          end
        end
        S_EVAL: begin
          if (!bad) begin
            if (!found) begin
              first <= tap;
              found <= 1'b1;
            end
            last  <= tap;
            state <= (tap == TAP_LAST) ? S_CENTER : S_STEP;
          end else if (found) begin
            state <= S_CENTER;
          end else if (tap == TAP_LAST) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end else begin
            state <= S_STEP;
          end
        end
        S_STEP: begin
          tap   <= tap + 8'd1;
          state <= S_CLEAR;
        end
        S_CENTER: begin
          if (win_short) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end else begin
            center_q <= sum[8:1];
            state    <= S_CLOAD;
          end
        end
        S_CLOAD: begin
          cnt   <= '0;
          state <= S_CSETTLE;
        end
        S_CSETTLE: begin
          if (DELAY_LINE_OUT_OF_RANGE) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end else if (cnt == SETTLE_LAST) begin
            if (center_q == 8'd0) begin
              done_q <= 1'b1;
              state  <= S_IDLE;
            end else begin
              mv_left <= center_q;
              state   <= S_CMOVE;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_CMOVE: begin
          if (DELAY_LINE_OUT_OF_RANGE) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end else begin
            mv_left <= mv_left - 8'd1;
            state   <= S_CGAP;
          end
        end
        S_CGAP: begin
          if (DELAY_LINE_OUT_OF_RANGE) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end else if (mv_left == 8'd0) begin
            done_q <= 1'b1;
            state  <= S_IDLE;
          end else begin
            state <= S_CMOVE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_iod_rd_eye_trainer.sv
// Self-checking bench for ddr_iod_rd_eye_trainer: behavioural IOD/eye model plus a result scoreboard.
module tb_ddr_iod_rd_eye_trainer;

  localparam int SETTLE = 8;
  localparam int SAMPLE = 16;
  localparam int BUDGET = 6000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       train_start = 1'b0;
  logic       oor = 1'b0;
  logic       busy, done, err, dl_load, dl_move, dl_dir, clr;
  logic       early, late;
  logic [7:0] tap_center;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pos = 0;
  int moves_since_load = 0;
  int move_total = 0;
  int load_cnt = 0;
  int win_lo = 0;
  int win_hi = -1;
  bit use_late = 1'b0;

  typedef struct {
    string      name;
    logic       done;
    logic       err;
    logic [7:0] center;
    int         moves;
  } exp_t;
  exp_t sb[$];

  ddr_iod_rd_eye_trainer dut (
    .FAB_CLK                 (clk),
    .ARST_N                  (rst_n),
    .TRAIN_START             (train_start),
    .TRAIN_BUSY              (busy),
    .TRAIN_DONE              (done),
    .TRAIN_ERR               (err),
    .TAP_CENTER              (tap_center),
    .DELAY_LINE_LOAD         (dl_load),
    .DELAY_LINE_MOVE         (dl_move),
    .DELAY_LINE_DIRECTION    (dl_dir),
    .DELAY_LINE_OUT_OF_RANGE (oor),
    .EYE_MONITOR_CLEAR_FLAGS (clr),
    .EYE_MONITOR_EARLY       (early),
    .EYE_MONITOR_LATE        (late)
  );

  always #5 clk = ~clk;

  // Eye model: flags are clean only while the delay line sits inside the window.
  assign early = !use_late && !((pos >= win_lo) && (pos <= win_hi));
  assign late  =  use_late && !((pos >= win_lo) && (pos <= win_hi));

  // Delay-line tracker and pulse exclusivity monitor, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (dl_load) begin
      pos = 0;
      moves_since_load = 0;
      load_cnt++;
    end
    if (dl_move) begin
      pos++;
      moves_since_load++;
      move_total++;
    end
    if (dl_load || dl_move || clr) begin
      checks++;
      if ((int'(dl_load) + int'(dl_move) + int'(clr)) > 1) begin
        errors++;
        $display("[TB] FAIL pulse_exclusive at cycle %0d: load=%0b move=%0b clear=%0b, required at most one", cyc, dl_load, dl_move, clr);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_eye(input int lo, input int hi, input bit lt);
    win_lo = lo;
    win_hi = hi;
    use_late = lt;
  endtask

  task automatic push_exp(input string name, input logic d, input logic e, input logic [7:0] c, input int m);
    exp_t x;
    x.name = name;
    x.done = d;
    x.err = e;
    x.center = c;
    x.moves = m;
    sb.push_back(x);
  endtask

  // Pulses start for one cycle; the accepting edge must immediately produce LOAD with BUSY.
  task automatic start_training(input string name);
    tick();
    train_start = 1'b1;
    tick();
    train_start = 1'b0;
    checks++;
    if (dl_load !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_start: load=%0b busy=%0b, required load=1 busy=1", name, dl_load, busy);
    end
  endtask

  task automatic wait_until_move(input int target, input string name);
    int n = 0;
    while (move_total < target && n < BUDGET) begin
      tick();
      n++;
    end
    if (move_total < target) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: move_total=%0d, required %0d", name, move_total, target);
    end
  endtask

  task automatic finish_and_score();
    int n = 0;
    exp_t x;
    while (busy === 1'b1 && n < BUDGET) begin
      tick();
      n++;
    end
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty: got a result with no expectation queued");
      return;
    end
    x = sb.pop_front();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_timeout: busy=%0b after %0d cycles, required 0", x.name, busy, n);
    end
    checks++;
    if (done !== x.done || err !== x.err) begin
      errors++;
      $display("[TB] FAIL %s_status: done=%0b err=%0b, required done=%0b err=%0b", x.name, done, err, x.done, x.err);
    end
    checks++;
    if (tap_center !== x.center) begin
      errors++;
      $display("[TB] FAIL %s_center: tap_center=%0d, required %0d", x.name, tap_center, x.center);
    end
    checks++;
    if (moves_since_load != x.moves) begin
      errors++;
      $display("[TB] FAIL %s_moves: moves after last load=%0d, required %0d", x.name, moves_since_load, x.moves);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #13;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || dl_load !== 1'b0 || dl_move !== 1'b0 ||
        clr !== 1'b0 || dl_dir !== 1'b1 || tap_center !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_values: busy=%0b done=%0b err=%0b load=%0b move=%0b clr=%0b dir=%0b center=%0d, required 0 0 0 0 0 0 1 0",
               busy, done, err, dl_load, dl_move, clr, dl_dir, tap_center);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_window();
    int m0, t1, lc;
    set_eye(10, 30, 1'b0);
    push_exp("window_10_30", 1'b1, 1'b0, 8'd20, 20);
    start_training("window_10_30");
    m0 = move_total;
    wait_until_move(m0 + 1, "tap_time_a");
    t1 = cyc;
    wait_until_move(m0 + 2, "tap_time_b");
    checks++;
    if (cyc - t1 != SETTLE + SAMPLE + 3) begin
      errors++;
      $display("[TB] FAIL tap_period: cycles between moves=%0d, required %0d", cyc - t1, SETTLE + SAMPLE + 3);
    end
    lc = load_cnt;
    train_start = 1'b1;
    tick();
    train_start = 1'b0;
    tick();
    checks++;
    if (dl_load !== 1'b0 || load_cnt != lc || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_start_ignored: load=%0b loads=%0d busy=%0b, required load=0 loads=%0d busy=1", dl_load, load_cnt, busy, lc);
    end
    finish_and_score();
    repeat (5) tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_not_queued: busy=%0b done=%0b, required busy=0 done=1", busy, done);
    end
  endtask

  task automatic test_no_pass();
    set_eye(1, 0, 1'b0);
    push_exp("no_pass", 1'b0, 1'b1, 8'd0, 127);
    start_training("no_pass");
    finish_and_score();
  endtask

  task automatic test_out_of_range();
    int n = 0;
    set_eye(50, 60, 1'b0);
    push_exp("out_of_range", 1'b0, 1'b1, 8'd0, 5);
    start_training("out_of_range");
    while (!(moves_since_load == 5 && clr === 1'b1) && n < BUDGET) begin
      tick();
      n++;
    end
    repeat (11) tick();
    oor = 1'b1;
    tick();
    oor = 1'b0;
    checks++;
    if (busy !== 1'b0 || err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL oor_next_cycle: busy=%0b err=%0b, required busy=0 err=1", busy, err);
    end
    repeat (40) tick();
    finish_and_score();
  endtask

  task automatic test_narrow_window();
    set_eye(10, 12, 1'b1);
`ifdef DDR_RD_TRAIN_MIN_WIDTH_EN
    push_exp("narrow_10_12", 1'b0, 1'b1, 8'd0, 13);
`else
    push_exp("narrow_10_12", 1'b1, 1'b0, 8'd11, 11);
`endif
    start_training("narrow_10_12");
    finish_and_score();
  endtask

  task automatic test_edge_window();
    set_eye(120, 127, 1'b1);
    push_exp("edge_120_127", 1'b1, 1'b0, 8'd123, 123);
    start_training("edge_120_127");
    finish_and_score();
  endtask

  task automatic test_reset_restart();
    int n = 0;
    set_eye(50, 60, 1'b0);
    start_training("pre_reset");
    while (moves_since_load < 40 && n < BUDGET) begin
      tick();
      n++;
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || dl_load !== 1'b0 || dl_move !== 1'b0 ||
        clr !== 1'b0 || dl_dir !== 1'b1 || tap_center !== 8'd0) begin
      errors++;
      $display("[TB] FAIL midrun_reset: busy=%0b done=%0b err=%0b load=%0b move=%0b clr=%0b dir=%0b center=%0d, required 0 0 0 0 0 0 1 0",
               busy, done, err, dl_load, dl_move, clr, dl_dir, tap_center);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    push_exp("restart_50_60", 1'b1, 1'b0, 8'd55, 55);
    start_training("restart");
    finish_and_score();
  endtask

  initial begin
    test_reset();
    test_window();
    test_no_pass();
    test_out_of_range();
    test_narrow_window();
    test_edge_window();
    test_reset_restart();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_leftover: %0d expectations unconsumed, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
